// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: sweeps the file to zero after reset, arbitrates write-back vs operand reads,
// and tags read data. Optional grant/conflict counters are enabled with RFC_PERF_EN.
module regfile_access_ctrl #(
   parameter int DW            = 32,
   parameter int AW            = 3,
   parameter int WR_STREAK_MAX = 4,
   parameter int INIT_CLEAR    = 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          wb_req,
   input  logic [AW-1:0] wb_dr,
   input  logic [DW-1:0] wb_data,
   output logic          wb_ack,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_sa,
   input  logic [AW-1:0] rd_sb,
   output logic          rd_ack,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data_a,
   output logic [DW-1:0] rd_data_b,
   output logic          busy,
   output logic          rf_ld,
   output logic [AW-1:0] rf_sa,
   output logic [AW-1:0] rf_sb,
   output logic [AW-1:0] rf_dr,
   output logic [DW-1:0] rf_din,
   input  logic [DW-1:0] rf_data_a,
   input  logic [DW-1:0] rf_data_b
`ifdef RFC_PERF_EN
   ,
   output logic [15:0]   perf_wr_cnt,
   output logic [15:0]   perf_rd_cnt,
   output logic [15:0]   perf_conflict_cnt
`endif
);

   localparam int SW = $clog2(WR_STREAK_MAX + 1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t        state;
   logic [AW-1:0] init_ptr;
   logic [SW-1:0] streak;
   logic          vld_p0;
   logic          run;
   logic          streak_full;

   assign run         = (state == ST_RUN);
   assign busy        = (state == ST_INIT);
   assign streak_full = (streak == SW'(WR_STREAK_MAX));

   // Writes win unless a waiting read has already been passed over WR_STREAK_MAX times.
   assign wb_ack = run & wb_req & ~(rd_req & streak_full);
   assign rd_ack = run & rd_req & ~wb_ack;

   assign rd_data_a = rf_data_a;
   assign rd_data_b = rf_data_b;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
         init_ptr <= '0;
         streak   <= '0;
         vld_p0   <= 1'b0;
         rd_valid <= 1'b0;
         rf_ld    <= 1'b0;
         rf_sa    <= '0;
         rf_sb    <= '0;
         rf_dr    <= '0;
         rf_din   <= '0;
      end else begin
         // p0: read command presented to the file; p1: file output registered, data valid
         vld_p0   <= rd_ack;
         rd_valid <= vld_p0;
         if (state == ST_INIT) begin
            rf_ld    <= 1'b1;
            rf_dr    <= init_ptr;
            rf_din   <= '0;
            init_ptr <= init_ptr + 1'b1;
            if (init_ptr == '1)
               state <= ST_RUN;
         end else begin
            rf_ld <= wb_ack;
            if (wb_ack) begin
               rf_dr  <= wb_dr;
               rf_din <= wb_data;
            end
            if (rd_ack) begin
               rf_sa <= rd_sa;
               rf_sb <= rd_sb;
            end
            if (rd_ack || !rd_req)
               streak <= '0;
            else if (wb_ack && !streak_full)
               streak <= streak + 1'b1;
         end
      end
   end

`ifdef RFC_PERF_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         perf_wr_cnt       <= '0;
         perf_rd_cnt       <= '0;
         perf_conflict_cnt <= '0;
      end else begin
         if (wb_ack && perf_wr_cnt != 16'hFFFF)
            perf_wr_cnt <= perf_wr_cnt + 16'd1;
         if (rd_ack && perf_rd_cnt != 16'hFFFF)
            perf_rd_cnt <= perf_rd_cnt + 16'd1;
         if (run && wb_req && rd_req && perf_conflict_cnt != 16'hFFFF)
            perf_conflict_cnt <= perf_conflict_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural 8x32 register file attached.
module tb_regfile_access_ctrl;

   localparam int DW = 32;
   localparam int AW = 3;

   logic          CLK = 1'b0;
   logic          RST;
   logic          wb_req, rd_req;
   logic [AW-1:0] wb_dr, rd_sa, rd_sb;
   logic [DW-1:0] wb_data;
   logic          wb_ack, rd_ack, rd_valid, busy, rf_ld;
   logic [DW-1:0] rd_data_a, rd_data_b, rf_din, rf_data_a, rf_data_b;
   logic [AW-1:0] rf_sa, rf_sb, rf_dr;
`ifdef RFC_PERF_EN
   logic [15:0]   perf_wr_cnt, perf_rd_cnt, perf_conflict_cnt;
`endif

   logic [DW-1:0] mem [8];
   int            n_chk = 0;
   int            n_pass = 0;
   logic [9:0]    wr_pattern;

   always #5 CLK = ~CLK;

   regfile_access_ctrl dut (
      .CLK(CLK), .RST(RST),
      .wb_req(wb_req), .wb_dr(wb_dr), .wb_data(wb_data), .wb_ack(wb_ack),
      .rd_req(rd_req), .rd_sa(rd_sa), .rd_sb(rd_sb), .rd_ack(rd_ack),
      .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .busy(busy), .rf_ld(rf_ld), .rf_sa(rf_sa), .rf_sb(rf_sb), .rf_dr(rf_dr),
      .rf_din(rf_din), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b)
`ifdef RFC_PERF_EN
      , .perf_wr_cnt(perf_wr_cnt), .perf_rd_cnt(perf_rd_cnt),
      .perf_conflict_cnt(perf_conflict_cnt)
`endif
   );

   // Register file: one write or one dual read per clock, registered read data.
   always @(posedge CLK) begin
      if (rf_ld)
         mem[rf_dr] <= rf_din;
      else begin
         rf_data_a <= mem[rf_sa];
         rf_data_b <= mem[rf_sb];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Expects INIT with init_ptr=0 in the current cycle; walks all 8 sweep writes.
   task automatic check_sweep();
      for (int i = 0; i < 8; i++) begin
         #1;
         check("init_busy", 32'(busy), 32'd1);
         check("init_wb_ack", 32'(wb_ack), 32'd0);
         check("init_rd_ack", 32'(rd_ack), 32'd0);
         check("init_rd_valid", 32'(rd_valid), 32'd0);
         tick();
         check("init_rf_ld", 32'(rf_ld), 32'd1);
         check("init_rf_dr", 32'(rf_dr), 32'(i));
         check("init_rf_din", rf_din, 32'd0);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
      rf_data_a = '0; rf_data_b = '0;
      RST = 1'b1; wb_req = 1'b0; rd_req = 1'b0;
      wb_dr = '0; wb_data = '0; rd_sa = '0; rd_sb = '0;
      tick(); tick();

      check("rst_rf_ld", 32'(rf_ld), 32'd0);
      check("rst_rf_dr", 32'(rf_dr), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);

      // Sweep with a read pending; the read is granted in the first RUN cycle.
      RST = 1'b0; rd_req = 1'b1; rd_sa = 3'd3; rd_sb = 3'd5;
      check_sweep();
      check("run_busy", 32'(busy), 32'd0);
      check("clr_rd_ack", 32'(rd_ack), 32'd1);
      tick();
      rd_req = 1'b0; #1;
      check("clr_cmd_ld", 32'(rf_ld), 32'd0);
      check("clr_cmd_sa", 32'(rf_sa), 32'd3);
      check("clr_cmd_sb", 32'(rf_sb), 32'd5);
      check("clr_vld_early", 32'(rd_valid), 32'd0);
      tick();
      check("clr_vld", 32'(rd_valid), 32'd1);
      check("clr_data_a", rd_data_a, 32'd0);
      check("clr_data_b", rd_data_b, 32'd0);
      tick();
      check("clr_vld_pulse", 32'(rd_valid), 32'd0);

      // Read-after-write: write in N, read in N+1, data in N+3.
      wb_req = 1'b1; wb_dr = 3'd2; wb_data = 32'hDEAD_BEEF; #1;
      check("raw_wb_ack", 32'(wb_ack), 32'd1);
      check("raw_rd_ack0", 32'(rd_ack), 32'd0);
      tick();
      wb_req = 1'b0; rd_req = 1'b1; rd_sa = 3'd2; rd_sb = 3'd0; #1;
      check("raw_rd_ack", 32'(rd_ack), 32'd1);
      check("raw_cmd_din", rf_din, 32'hDEAD_BEEF);
      tick();
      rd_req = 1'b0; #1;
      check("raw_vld_early", 32'(rd_valid), 32'd0);
      tick();
      check("raw_vld", 32'(rd_valid), 32'd1);
      check("raw_data_a", rd_data_a, 32'hDEAD_BEEF);
      check("raw_data_b", rd_data_b, 32'd0);

      // Preload r1..r4 with 0x11..0x44.
      for (int i = 1; i <= 4; i++) begin
         wb_req = 1'b1; wb_dr = 3'(i); wb_data = 32'h11 * 32'(i); #1;
         check("pre_wb_ack", 32'(wb_ack), 32'd1);
         tick();
      end
      wb_req = 1'b0;

      // Four back-to-back reads: A walks r1..r4, B walks r4..r1.
      for (int k = 0; k < 7; k++) begin
         rd_req = (k < 4); rd_sa = 3'(k + 1); rd_sb = 3'(4 - k); #1;
         if (k < 4) check("b2b_rd_ack", 32'(rd_ack), 32'd1);
         if (k >= 2 && k < 6) begin
            check("b2b_vld", 32'(rd_valid), 32'd1);
            check("b2b_data_a", rd_data_a, 32'h11 * 32'(k - 1));
            check("b2b_data_b", rd_data_b, 32'h11 * 32'(6 - k));
         end else
            check("b2b_vld_idle", 32'(rd_valid), 32'd0);
         tick();
      end

      // Both requesters held: W,W,W,W,R repeating.
      wr_pattern = 10'b01111_01111;
      wb_req = 1'b1; wb_dr = 3'd7; wb_data = 32'h77;
      rd_req = 1'b1; rd_sa = 3'd7; rd_sb = 3'd2;
      for (int k = 0; k < 10; k++) begin
         #1;
         check("arb_wb_ack", 32'(wb_ack), 32'(wr_pattern[k]));
         check("arb_rd_ack", 32'(rd_ack), 32'(!wr_pattern[k]));
         tick();
      end
      wb_req = 1'b0; rd_req = 1'b0;
      tick(); tick(); tick();
`ifdef RFC_PERF_EN
      check("perf_conflict", 32'(perf_conflict_cnt), 32'd10);
      check("perf_wr", 32'(perf_wr_cnt), 32'd13);
      check("perf_rd", 32'(perf_rd_cnt), 32'd8);
      check("perf_sum", 32'(perf_wr_cnt) + 32'(perf_rd_cnt), 32'd21);
`endif

      // Reset with a read in flight: its rd_valid must never appear.
      rd_req = 1'b1; rd_sa = 3'd1; rd_sb = 3'd2; #1;
      check("drop_rd_ack", 32'(rd_ack), 32'd1);
      tick();
      RST = 1'b1; rd_req = 1'b0;
      tick();
      RST = 1'b0; #1;
      check("drop_vld", 32'(rd_valid), 32'd0);
      check("drop_busy", 32'(busy), 32'd1);
      check("drop_rf_ld", 32'(rf_ld), 32'd0);
`ifdef RFC_PERF_EN
      check("perf_rst", 32'(perf_wr_cnt), 32'd0);
`endif
      for (int i = 0; i < 4; i++) begin
         tick();
         check("part_rf_dr", 32'(rf_dr), 32'(i));
         check("part_vld", 32'(rd_valid), 32'd0);
      end

      // Reset again at init_ptr=4; the sweep restarts from 0.
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("rst2_rf_ld", 32'(rf_ld), 32'd0);
      check("rst2_rf_dr", 32'(rf_dr), 32'd0);
      check_sweep();
      check("rst2_run", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Sequences the 8x32 register file (LD/SA/SB/DR/D_IN in, registered DATA_A/DATA_B out) and shares it between a write-back requester and an operand-read requester.
- The register file performs either one write (LD=1) or one dual read (LD=0) per clock; this block arbitrates, drives the file's command inputs from registers, and tags returning read data.
- After reset it clears all registers with a zero-write sweep.
- Sits between decode/write-back logic and register_file.

Parameters:
- DW, 32, data width
- AW, 3, register address width (2**AW registers)
- WR_STREAK_MAX, 4, consecutive write grants allowed while a read waits; the next grant goes to the read
- INIT_CLEAR, 1, 1 = run the zero-write sweep after reset; 0 = go straight to RUN

Ports:
- CLK  in  1  clock; all logic on posedge
- RST  in  1  synchronous, active-high reset
- wb_req  in  1  write request; held with operands until wb_ack
- wb_dr  in  AW  write address
- wb_data  in  DW  write data
- wb_ack  out  1  write granted this cycle (combinational)
- rd_req  in  1  read request; held with operands until rd_ack
- rd_sa  in  AW  operand A address
- rd_sb  in  AW  operand B address
- rd_ack  out  1  read granted this cycle (combinational)
- rd_valid  out  1  rd_data_a/b valid this cycle (single-cycle pulse)
- rd_data_a  out  DW  pass-through of rf_data_a
- rd_data_b  out  DW  pass-through of rf_data_b
- busy  out  1  high during INIT
- rf_ld  out  1  to file LD
- rf_sa  out  AW  to file SA
- rf_sb  out  AW  to file SB
- rf_dr  out  AW  to file DR
- rf_din  out  DW  to file D_IN
- rf_data_a  in  DW  from file DATA_A
- rf_data_b  in  DW  from file DATA_B

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset values: rf_ld=0, rf_sa=rf_sb=rf_dr=0, rf_din=0, rd_valid=0, the read-pipeline valid bits=0, streak=0, init_ptr=0.
- State after reset: INIT if INIT_CLEAR=1, else RUN. RST asserted in any state, including mid-sweep or with a read in flight, restarts from reset values. In-flight reads are dropped and no rd_valid is issued for them.
- INIT state:
  - busy=1, wb_ack=rd_ack=0.
  - Each cycle registers rf_ld=1, rf_dr=init_ptr, rf_din=0, then increments init_ptr.
  - After address 2**AW-1 is issued, the next state is RUN.
  - Sweep length is 2**AW cycles (8 by default).
- RUN arbitration, evaluated combinationally each cycle:
  - Only wb_req: wb_ack=1.
  - Only rd_req: rd_ack=1.
  - Both requests: wb_ack=1 unless streak==WR_STREAK_MAX, in which case rd_ack=1.
  - Never both acks in one cycle.
- Streak counter:
  - Increments on a write grant while rd_req=1, saturating at WR_STREAK_MAX.
  - Clears on any read grant, or on any cycle with rd_req=0.
- Command registers, loaded at the edge ending the grant cycle N:
  - Write grant: rf_ld=1, rf_dr=wb_dr, rf_din=wb_data.
  - Read grant: rf_ld=0, rf_sa=rd_sa, rf_sb=rd_sb.
  - No grant: rf_ld=0; addresses and data hold their last values. The file then does a harmless read, which is not tagged.
- Latency:
  - Grant in cycle N, command presented to the file in N+1, file acts at the end of N+1.
  - Write: visible to any read granted in N+1 or later.
  - Read: rd_valid=1 in cycle N+2, with rd_data_a/b = file contents at the end of N+1.
- Read tagging: a 2-stage valid pipeline produces rd_valid.
  - Back-to-back read grants give back-to-back rd_valid.
  - The consumer must capture data while rd_valid=1. The file drives X on DATA_A/B after a write cycle, so data is undefined whenever rd_valid=0.
- Read-after-write: a write granted in N and a read of the same address granted in N+1 returns the new data. No forwarding logic is needed.

Optional Feature:
- Macro: RFC_PERF_EN.
- When defined, adds three outputs, all reset to 0 on RST:
  - perf_wr_cnt (16): write grants in RUN, saturating at 16'hFFFF.
  - perf_rd_cnt (16): read grants in RUN, saturating at 16'hFFFF.
  - perf_conflict_cnt (16): RUN cycles with wb_req=1 and rd_req=1, saturating at 16'hFFFF.
- When undefined, these ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset, INIT_CLEAR=1 -> busy=1 for exactly 8 cycles with rf_ld=1, rf_dr=0..7, rf_din=0; afterwards a read of addresses 3 and 5 returns 0 and 0.
- Write r2=0xDEADBEEF granted in cycle N, read sa=2/sb=0 granted in N+1 -> rd_valid=1 in N+3 with rd_data_a=0xDEADBEEF, rd_data_b=0.
- wb_req and rd_req held continuously, WR_STREAK_MAX=4 -> grant pattern W,W,W,W,R repeating; never both acks high in one cycle.
- Reads granted back-to-back for 4 cycles (addresses 1..4, preloaded with 0x11..0x44) -> 4 consecutive rd_valid pulses carrying 0x11,0x22,0x33,0x44 in order.
- RST pulsed in cycle N+1 after a read grant in N, and again mid-INIT at init_ptr=4 -> no rd_valid appears; INIT restarts at rf_dr=0 and runs a full 8 cycles.
- With RFC_PERF_EN: 10 conflicting cycles -> perf_conflict_cnt=10; perf_wr_cnt+perf_rd_cnt equals the number of acks issued.
